// File: rtl/led_bounce_decoder_pkg.sv
// Shared definitions for the bouncing-LED decoder.
// Holds the phase constants P00..P13 of the 14-phase sequence 0,1..7,6..1.
// Also holds the phase -> LED index mapping and the FSM state encoding.
package led_bounce_decoder_pkg;

    localparam int NPHASE = 14;

    localparam logic [3:0] P00 = 4'd0;
    localparam logic [3:0] P01 = 4'd1;
    localparam logic [3:0] P02 = 4'd2;
    localparam logic [3:0] P03 = 4'd3;
    localparam logic [3:0] P04 = 4'd4;
    localparam logic [3:0] P05 = 4'd5;
    localparam logic [3:0] P06 = 4'd6;
    localparam logic [3:0] P07 = 4'd7;
    localparam logic [3:0] P08 = 4'd8;
    localparam logic [3:0] P09 = 4'd9;
    localparam logic [3:0] P10 = 4'd10;
    localparam logic [3:0] P11 = 4'd11;
    localparam logic [3:0] P12 = 4'd12;
    localparam logic [3:0] P13 = 4'd13;

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    // The rising half of the bounce maps a phase to itself.
    // The falling half mirrors it, so phase p maps to 14-p.
    function automatic logic [2:0] phase_to_led(input logic [3:0] p);
        logic [3:0] m;
        m = (p <= P07) ? p : (4'(NPHASE) - p);
        return m[2:0];
    endfunction

endpackage

// File: rtl/led_onehot_encoder.sv
// Combinational one-hot check and encoder for the sampled LED word.
//   ledg   in  8  sampled LED word
//   onehot out 1  exactly one bit of ledg is set
//   idx    out 3  position of the set bit (meaningful only when onehot)
module led_onehot_encoder (
    input  logic [7:0] ledg,
    output logic       onehot,
    output logic [2:0] idx
);
    logic [3:0] cnt;

    always_comb begin
        cnt = '0;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (ledg[i]) begin
                cnt = cnt + 4'd1;
                idx = 3'(i);
            end
        end
        onehot = (cnt == 4'd1);
    end
endmodule

// File: rtl/led_bounce_decoder.sv
// Receive-side checker and decoder for the 8-LED bouncing-light pattern.
// It locks onto the 14-phase bounce and reports phase, LED index and direction.
// It flags and counts every sample that breaks the sequence while locked.
//   CLK      in  1      clock, posedge
//   RST      in  1      synchronous active-high reset
//   VALID    in  1      LEDG carries a new sample
//   LEDG     in  8      LED word, expected one-hot
//   ERR_CLR  in  1      clear ERR_CNT
//   POS      out 4      locked phase 0..13
//   LED_IDX  out 3      LED index of POS
//   DIR      out 1      0 = up (POS 0..6), 1 = down (POS 7..13)
//   LOCKED   out 1      synchronised to the sequence
//   ERR      out 1      pulse: sample rejected while locked
//   WRAP     out 1      pulse: accepted 13 -> 0 transition
//   ERR_CNT  out ERR_W  saturating count of ERR pulses
module led_bounce_decoder
    import led_bounce_decoder_pkg::*;
#(
    parameter int MAX_MISS = 2,
    parameter int ERR_W    = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             VALID,
    input  logic [7:0]       LEDG,
    input  logic             ERR_CLR,
    output logic [3:0]       POS,
    output logic [2:0]       LED_IDX,
    output logic             DIR,
    output logic             LOCKED,
    output logic             ERR,
    output logic             WRAP,
    output logic [ERR_W-1:0] ERR_CNT
);
    state_t     state, state_n;
    logic [3:0] pos_n, exp_pos;
    logic [2:0] prev, prev_n, miss, miss_n, miss_inc;
    logic       err_n, wrap_n, oh;
    logic [2:0] idx;
    logic [ERR_W-1:0] cnt_n;

    led_onehot_encoder u_enc (
        .ledg   (LEDG),
        .onehot (oh),
        .idx    (idx)
    );

    always_comb begin
        state_n  = state;
        pos_n    = POS;
        prev_n   = prev;
        miss_n   = miss;
        err_n    = 1'b0;
        wrap_n   = 1'b0;
        exp_pos  = (POS == P13) ? P00 : POS + 4'd1;
        miss_inc = miss + 3'd1;
        if (VALID) begin
            case (state)
                S_SEARCH: begin
                    // The end LEDs are unambiguous, so lock on them at once.
                    if (oh) begin
                        if (idx == 3'd0) begin
                            state_n = S_LOCKED;
                            pos_n   = P00;
                            miss_n  = '0;
                        end else if (idx == 3'd7) begin
                            state_n = S_LOCKED;
                            pos_n   = P07;
                            miss_n  = '0;
                        end else begin
                            state_n = S_ACQ;
                            prev_n  = idx;
                        end
                    end
                end
                S_ACQ: begin
                    // An inner LED alone gives no direction; two neighbours do.
                    if (!oh) begin
                        state_n = S_SEARCH;
                    end else if (idx == prev + 3'd1) begin
                        state_n = S_LOCKED;
                        pos_n   = {1'b0, idx};
                        miss_n  = '0;
                    end else if (idx == prev - 3'd1) begin
                        state_n = S_LOCKED;
                        pos_n   = (idx == 3'd0) ? P00 : 4'(NPHASE) - {1'b0, idx};
                        miss_n  = '0;
                    end else if (idx == 3'd0 || idx == 3'd7) begin
                        state_n = S_LOCKED;
                        pos_n   = {1'b0, idx};
                        miss_n  = '0;
                    end else begin
                        prev_n = idx;
                    end
                end
                S_LOCKED: begin
                    // The phase freewheels even on a bad sample, so a single
                    // glitch leaves the decoder in step with the generator.
                    pos_n = exp_pos;
                    if (LEDG == (8'd1 << phase_to_led(exp_pos))) begin
                        miss_n = '0;
                        wrap_n = (POS == P13);
                    end else begin
                        err_n = 1'b1;
                        if (miss_inc >= 3'(MAX_MISS)) begin
                            state_n = S_SEARCH;
                            pos_n   = P00;
                            miss_n  = '0;
                        end else begin
                            miss_n = miss_inc;
                        end
                    end
                end
                default: state_n = S_SEARCH;
            endcase
        end

        // A clear that coincides with an error keeps that error.
        cnt_n = ERR_CNT;
        if (ERR_CLR)
            cnt_n = err_n ? ERR_W'(1) : '0;
        else if (err_n && ERR_CNT != '1)
            cnt_n = ERR_CNT + ERR_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_SEARCH;
            POS     <= P00;
            prev    <= '0;
            miss    <= '0;
            LED_IDX <= '0;
            DIR     <= 1'b0;
            LOCKED  <= 1'b0;
            ERR     <= 1'b0;
            WRAP    <= 1'b0;
            ERR_CNT <= '0;
        end else begin
            state   <= state_n;
            POS     <= pos_n;
            prev    <= prev_n;
            miss    <= miss_n;
            LED_IDX <= phase_to_led(pos_n);
            DIR     <= (pos_n >= P07);
            LOCKED  <= (state_n == S_LOCKED);
            ERR     <= err_n;
            WRAP    <= wrap_n;
            ERR_CNT <= cnt_n;
        end
    end
endmodule

// File: tb/tb_led_bounce_decoder.sv
module tb_led_bounce_decoder;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       VALID = 1'b0;
    logic [7:0] LEDG = 8'h00;
    logic       ERR_CLR = 1'b0;
    logic [3:0] POS;
    logic [2:0] LED_IDX;
    logic       DIR, LOCKED, ERR, WRAP;
    logic [7:0] ERR_CNT;

    int compared = 0;
    int mismatched = 0;

    // Hand-written bounce: LED word and LED index for phases 0..13.
    logic [7:0] led_tab [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
    logic [2:0] idx_tab [14] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
                                 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};

    led_bounce_decoder #(.MAX_MISS(2), .ERR_W(8)) dut (
        .CLK(CLK), .RST(RST), .VALID(VALID), .LEDG(LEDG), .ERR_CLR(ERR_CLR),
        .POS(POS), .LED_IDX(LED_IDX), .DIR(DIR), .LOCKED(LOCKED),
        .ERR(ERR), .WRAP(WRAP), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    // Apply one cycle of inputs; outputs are examined 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic clr);
        VALID = v; LEDG = d; ERR_CLR = clr;
        @(posedge CLK); #1;
        VALID = 1'b0; LEDG = 8'h00; ERR_CLR = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step(1'b1, 8'h01, 1'b1);
        step(1'b0, 8'h80, 1'b0);
        RST = 1'b0;
        compared++;
        if ({POS, LED_IDX, DIR, LOCKED, ERR, WRAP, ERR_CNT} !== 22'd0) begin
            mismatched++;
            $display("FAIL reset_outputs got pos=%0d idx=%0d dir=%0b lk=%0b err=%0b wrap=%0b cnt=%0d want all 0",
                     POS, LED_IDX, DIR, LOCKED, ERR, WRAP, ERR_CNT);
        end
    endtask

    task automatic test_clean_lock();
        int wraps, errs;
        wraps = 0; errs = 0;
        do_reset();
        step(1'b1, 8'h01, 1'b0);
        compared++;
        if (LOCKED !== 1'b1 || POS !== 4'd0) begin
            mismatched++;
            $display("FAIL clean_first got lk=%0b pos=%0d want lk=1 pos=0", LOCKED, POS);
        end
        // 28 samples after the locking one: two full bounces, ending back at phase 0.
        for (int i = 1; i <= 28; i++) begin
            step(1'b1, led_tab[i % 14], 1'b0);
            if (WRAP === 1'b1) wraps++;
            if (ERR === 1'b1) errs++;
            compared++;
            if (POS !== 4'(i % 14) || LED_IDX !== idx_tab[i % 14] || DIR !== ((i % 14) >= 7)) begin
                mismatched++;
                $display("FAIL clean_seq[%0d] got pos=%0d idx=%0d dir=%0b want pos=%0d idx=%0d dir=%0b",
                         i, POS, LED_IDX, DIR, i % 14, idx_tab[i % 14], (i % 14) >= 7);
            end
        end
        compared++;
        if (wraps != 2 || errs != 0 || ERR_CNT !== 8'd0 || LOCKED !== 1'b1) begin
            mismatched++;
            $display("FAIL clean_totals got wraps=%0d errs=%0d cnt=%0d lk=%0b want 2 0 0 1",
                     wraps, errs, ERR_CNT, LOCKED);
        end
    endtask

    task automatic test_mid_acq();
        do_reset();
        step(1'b1, 8'h08, 1'b0);
        compared++;
        if (LOCKED !== 1'b0) begin
            mismatched++;
            $display("FAIL acq_first got lk=%0b want 0", LOCKED);
        end
        step(1'b1, 8'h04, 1'b0);
        compared++;
        if (LOCKED !== 1'b1 || POS !== 4'd12 || DIR !== 1'b1 || LED_IDX !== 3'd2) begin
            mismatched++;
            $display("FAIL acq_lock got lk=%0b pos=%0d dir=%0b idx=%0d want 1 12 1 2",
                     LOCKED, POS, DIR, LED_IDX);
        end
        step(1'b1, 8'h02, 1'b0);
        compared++;
        if (POS !== 4'd13 || ERR !== 1'b0) begin
            mismatched++;
            $display("FAIL acq_next got pos=%0d err=%0b want 13 0", POS, ERR);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h04, 1'b0);
        step(1'b1, 8'h08, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        compared++;
        if (ERR !== 1'b1 || POS !== 4'd4 || LOCKED !== 1'b1) begin
            mismatched++;
            $display("FAIL glitch_bad got err=%0b pos=%0d lk=%0b want 1 4 1", ERR, POS, LOCKED);
        end
        step(1'b1, 8'h20, 1'b0);
        compared++;
        if (ERR !== 1'b0 || POS !== 4'd5 || ERR_CNT !== 8'd1 || LOCKED !== 1'b1) begin
            mismatched++;
            $display("FAIL glitch_recover got err=%0b pos=%0d cnt=%0d lk=%0b want 0 5 1 1",
                     ERR, POS, ERR_CNT, LOCKED);
        end
    endtask

    // Continues from the glitch scenario: locked at POS=5, ERR_CNT=1.
    task automatic test_unlock();
        step(1'b1, 8'h00, 1'b0);
        compared++;
        if (LOCKED !== 1'b1 || POS !== 4'd6 || ERR !== 1'b1) begin
            mismatched++;
            $display("FAIL unlock_first got lk=%0b pos=%0d err=%0b want 1 6 1", LOCKED, POS, ERR);
        end
        step(1'b1, 8'h10, 1'b0);
        compared++;
        if (LOCKED !== 1'b0 || POS !== 4'd0 || ERR_CNT !== 8'd3 || ERR !== 1'b1) begin
            mismatched++;
            $display("FAIL unlock_drop got lk=%0b pos=%0d cnt=%0d err=%0b want 0 0 3 1",
                     LOCKED, POS, ERR_CNT, ERR);
        end
        step(1'b1, 8'h80, 1'b0);
        compared++;
        if (LOCKED !== 1'b1 || POS !== 4'd7 || DIR !== 1'b1 || LED_IDX !== 3'd7) begin
            mismatched++;
            $display("FAIL unlock_relock got lk=%0b pos=%0d dir=%0b idx=%0d want 1 7 1 7",
                     LOCKED, POS, DIR, LED_IDX);
        end
    endtask

    // Continues from POS=7.
    task automatic test_gaps();
        step(1'b1, 8'h40, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'hFF, 1'b0);
            compared++;
            if (POS !== 4'd8 || ERR !== 1'b0 || WRAP !== 1'b0 || LOCKED !== 1'b1) begin
                mismatched++;
                $display("FAIL gap[%0d] got pos=%0d err=%0b wrap=%0b lk=%0b want 8 0 0 1",
                         i, POS, ERR, WRAP, LOCKED);
            end
        end
        step(1'b1, 8'h20, 1'b0);
        compared++;
        if (POS !== 4'd9 || ERR !== 1'b0) begin
            mismatched++;
            $display("FAIL gap_resume got pos=%0d err=%0b want 9 0", POS, ERR);
        end
    endtask

    task automatic test_counter();
        do_reset();
        // Each pass: lock on LED0, then two bad samples (2 errors, unlock).
        for (int i = 0; i < 127; i++) begin
            step(1'b1, 8'h01, 1'b0);
            step(1'b1, 8'h00, 1'b0);
            step(1'b1, 8'h00, 1'b0);
        end
        compared++;
        if (ERR_CNT !== 8'd254) begin
            mismatched++;
            $display("FAIL cnt_254 got %0d want 254", ERR_CNT);
        end
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        compared++;
        if (ERR_CNT !== 8'hFF) begin
            mismatched++;
            $display("FAIL cnt_sat got %0d want 255", ERR_CNT);
        end
        step(1'b1, 8'h00, 1'b0);
        compared++;
        if (ERR_CNT !== 8'hFF || ERR !== 1'b1 || LOCKED !== 1'b0) begin
            mismatched++;
            $display("FAIL cnt_hold got cnt=%0d err=%0b lk=%0b want 255 1 0", ERR_CNT, ERR, LOCKED);
        end
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h00, 1'b1);
        compared++;
        if (ERR_CNT !== 8'd1 || ERR !== 1'b1) begin
            mismatched++;
            $display("FAIL clr_with_err got cnt=%0d err=%0b want 1 1", ERR_CNT, ERR);
        end
        step(1'b0, 8'h00, 1'b1);
        compared++;
        if (ERR_CNT !== 8'd0) begin
            mismatched++;
            $display("FAIL clr_alone got %0d want 0", ERR_CNT);
        end
    endtask

    task automatic test_mid_reset();
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        RST = 1'b1;
        step(1'b1, 8'h04, 1'b0);
        RST = 1'b0;
        compared++;
        if (LOCKED !== 1'b0 || POS !== 4'd0 || ERR_CNT !== 8'd0) begin
            mismatched++;
            $display("FAIL midrst got lk=%0b pos=%0d cnt=%0d want 0 0 0", LOCKED, POS, ERR_CNT);
        end
        // An inner LED alone only starts acquisition.
        step(1'b1, 8'h08, 1'b0);
        compared++;
        if (LOCKED !== 1'b0 || ERR !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_acq got lk=%0b err=%0b want 0 0", LOCKED, ERR);
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_mid_acq();
        test_glitch();
        test_unlock();
        test_gaps();
        test_counter();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
